// File: rtl/bank_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory bank among PORTS requesters.
// Accepted commands are registered toward the bank; read data returns on per-port lanes.
module bank_port_arbiter #(
   parameter int PORTS      = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   localparam int ID_WIDTH  = ($clog2(PORTS) > 1) ? $clog2(PORTS) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [PORTS-1:0]                     req_valid,
   input  logic [PORTS-1:0]                     req_we,
   input  logic [PORTS-1:0][ADDR_WIDTH-1:0]     req_addr,
   input  logic [PORTS-1:0][DATA_WIDTH-1:0]     req_wdata,
   output logic [PORTS-1:0]                     req_ready,
   output logic [PORTS-1:0]                     rsp_valid,
   output logic [PORTS-1:0][DATA_WIDTH-1:0]     rsp_data,
   output logic                                 mem_en,
   output logic                                 mem_we,
   output logic [ADDR_WIDTH-1:0]                mem_addr,
   output logic [DATA_WIDTH-1:0]                mem_wdata,
   input  logic                                 mem_stall,
   input  logic [DATA_WIDTH-1:0]                mem_rdata,
   output logic [ID_WIDTH-1:0]                  grant_id
);

   logic [ID_WIDTH-1:0] ptr;
   logic [ID_WIDTH-1:0] cand;
   logic [ID_WIDTH-1:0] ptr_nxt;
   logic [ID_WIDTH:0]   scan;
   logic                cand_v;
   logic                cmd_free;
   logic                fire;
   logic                pend_vld_p1;
   logic [ID_WIDTH-1:0] pend_id_p1;

   // p0: round-robin search from ptr; the extra scan bit absorbs the wrap before the modulo fold
   always_comb begin
      cand   = '0;
      cand_v = 1'b0;
      scan   = '0;
      for (int i = 0; i < PORTS; i++) begin
         scan = {1'b0, ptr} + (ID_WIDTH+1)'(i);
         if (scan >= (ID_WIDTH+1)'(PORTS))
            scan = scan - (ID_WIDTH+1)'(PORTS);
         if (!cand_v && req_valid[scan[ID_WIDTH-1:0]]) begin
            cand   = scan[ID_WIDTH-1:0];
            cand_v = 1'b1;
         end
      end
   end

   assign cmd_free = !mem_en || !mem_stall;
   assign fire     = cand_v && cmd_free && rst;
   assign ptr_nxt  = (cand == ID_WIDTH'(PORTS-1)) ? '0 : cand + 1'b1;

   always_comb begin
      req_ready = '0;
      if (fire)
         req_ready[cand] = 1'b1;
   end

   // p1: command register toward the bank; holds everything while the bank stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ptr       <= '0;
         grant_id  <= '0;
      end else if (fire) begin
         mem_en    <= 1'b1;
         mem_we    <= req_we[cand];
         mem_addr  <= req_addr[cand];
         mem_wdata <= req_wdata[cand];
         ptr       <= ptr_nxt;
         grant_id  <= cand;
      end else if (cmd_free) begin
         mem_en    <= 1'b0;
      end
   end

   // p2: remember which port owns the read the bank is answering this cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_vld_p1 <= 1'b0;
         pend_id_p1  <= '0;
      end else begin
         pend_vld_p1 <= mem_en && !mem_stall && !mem_we;
         pend_id_p1  <= grant_id;
      end
   end

   // p3: steer sampled read data onto the owner's lane, zero elsewhere so lanes OR across banks
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         for (int p = 0; p < PORTS; p++) begin
            rsp_valid[p] <= pend_vld_p1 && (pend_id_p1 == ID_WIDTH'(p));
            rsp_data[p]  <= (pend_vld_p1 && (pend_id_p1 == ID_WIDTH'(p))) ? mem_rdata : '0;
         end
      end
   end

endmodule
